// File: rtl/div_ctrl_pkg.sv
// Shared constants for the DIV/DIVU controller:
// state encoding, default width, result-bus layout.
package div_ctrl_pkg;

  localparam int DIV_DATA_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // dout_tdata = {quotient, remainder}, in DATA_W halves
  localparam int DOUT_R_HALF = 0;
  localparam int DOUT_Q_HALF = 1;

endpackage

// File: rtl/div_sign_fix.sv
// Two-lane conditional negate; gives operand magnitudes
// on the way in and signed Q/R on the way out.
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         a_neg,
  input  logic [W-1:0] b,
  input  logic         b_neg,
  output logic [W-1:0] a_fix,
  output logic [W-1:0] b_fix
);

  assign a_fix = a_neg ? (-a) : a;
  assign b_fix = b_neg ? (-b) : b;

endmodule

// File: rtl/div_ctrl.sv
// EX-stage controller for DIV/DIVU: feeds an AXI-stream
// divider and writes sign-corrected results to HI/LO.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                op_valid,
  input  logic                op_signed,
  input  logic [DATA_W-1:0]   op_src1,
  input  logic [DATA_W-1:0]   op_src2,
  input  logic                op_flush,
  input  logic                op_advance,
  output logic                op_ready,
  output logic                busy,
  output logic                dividend_tvalid,
  input  logic                dividend_tready,
  output logic [DATA_W-1:0]   dividend_tdata,
  output logic                divisor_tvalid,
  input  logic                divisor_tready,
  output logic [DATA_W-1:0]   divisor_tdata,
  input  logic                dout_tvalid,
  input  logic [2*DATA_W-1:0] dout_tdata,
  output logic                hi_we,
  output logic [DATA_W-1:0]   hi_wdata,
  output logic                lo_we,
  output logic [DATA_W-1:0]   lo_wdata
);

  logic [1:0]        state;
  logic              drop;
  logic              q_neg;
  logic              r_neg;
  logic              s1_neg;
  logic              s2_neg;
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic              dvd_done;
  logic              dvs_done;

  assign s1_neg = op_signed & op_src1[DATA_W-1];
  assign s2_neg = op_signed & op_src2[DATA_W-1];

  assign quo = dout_tdata[DOUT_Q_HALF*DATA_W +: DATA_W];
  assign rem = dout_tdata[DOUT_R_HALF*DATA_W +: DATA_W];

  div_sign_fix #(.W(DATA_W)) u_pre (
    .a     (op_src1),
    .a_neg (s1_neg),
    .b     (op_src2),
    .b_neg (s2_neg),
    .a_fix (mag1),
    .b_fix (mag2)
  );

  div_sign_fix #(.W(DATA_W)) u_post (
    .a     (quo),
    .a_neg (q_neg),
    .b     (rem),
    .b_neg (r_neg),
    .a_fix (quo_fix),
    .b_fix (rem_fix)
  );

  // A channel is finished once its beat is accepted
  assign dvd_done = !dividend_tvalid || dividend_tready;
  assign dvs_done = !divisor_tvalid || divisor_tready;

  assign op_ready = (state == S_DONE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      drop            <= 1'b0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      dividend_tvalid <= 1'b0;
      divisor_tvalid  <= 1'b0;
      dividend_tdata  <= '0;
      divisor_tdata   <= '0;
      hi_we           <= 1'b0;
      lo_we           <= 1'b0;
      hi_wdata        <= '0;
      lo_wdata        <= '0;
    end else begin
      hi_we <= 1'b0;
      lo_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (op_valid && !op_flush) begin
            dividend_tdata  <= mag1;
            divisor_tdata   <= mag2;
            q_neg           <= s1_neg ^ s2_neg;
            r_neg           <= s1_neg;
            dividend_tvalid <= 1'b1;
            divisor_tvalid  <= 1'b1;
            drop            <= 1'b0;
            state           <= S_SEND;
          end
        end
        S_SEND: begin
          if (dividend_tvalid && dividend_tready)
            dividend_tvalid <= 1'b0;
          if (divisor_tvalid && divisor_tready)
            divisor_tvalid <= 1'b0;
          if (op_flush)
            drop <= 1'b1;
          if (dvd_done && dvs_done)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (dout_tvalid) begin
            if (drop || op_flush) begin
              state <= S_IDLE;
            end else begin
              hi_we    <= 1'b1;
              lo_we    <= 1'b1;
              hi_wdata <= rem_fix;
              lo_wdata <= quo_fix;
              state    <= S_DONE;
            end
          end else if (op_flush) begin
            drop <= 1'b1;
          end
        end
        S_DONE: begin
          if (op_flush || op_advance)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a hand-driven
// divider stream and fixed expected HI/LO values.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic        op_signed;
  logic [31:0] op_src1;
  logic [31:0] op_src2;
  logic        op_flush;
  logic        op_advance;
  logic        op_ready;
  logic        busy;
  logic        dividend_tvalid;
  logic        dividend_tready;
  logic [31:0] dividend_tdata;
  logic        divisor_tvalid;
  logic        divisor_tready;
  logic [31:0] divisor_tdata;
  logic        dout_tvalid;
  logic [63:0] dout_tdata;
  logic        hi_we;
  logic [31:0] hi_wdata;
  logic        lo_we;
  logic [31:0] lo_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  int dvd_cyc = 0;
  int dvs_cyc = 0;
  int hi_cnt  = 0;
  int lo_cnt  = 0;
  logic [31:0] cap_dvd = '0;
  logic [31:0] cap_dvs = '0;

  always #5 clk = ~clk;

  div_ctrl #(.DATA_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .op_valid        (op_valid),
    .op_signed       (op_signed),
    .op_src1         (op_src1),
    .op_src2         (op_src2),
    .op_flush        (op_flush),
    .op_advance      (op_advance),
    .op_ready        (op_ready),
    .busy            (busy),
    .dividend_tvalid (dividend_tvalid),
    .dividend_tready (dividend_tready),
    .dividend_tdata  (dividend_tdata),
    .divisor_tvalid  (divisor_tvalid),
    .divisor_tready  (divisor_tready),
    .divisor_tdata   (divisor_tdata),
    .dout_tvalid     (dout_tvalid),
    .dout_tdata      (dout_tdata),
    .hi_we           (hi_we),
    .hi_wdata        (hi_wdata),
    .lo_we           (lo_we),
    .lo_wdata        (lo_wdata)
  );

  always @(posedge clk) begin
    if (dividend_tvalid) dvd_cyc <= dvd_cyc + 1;
    if (divisor_tvalid)  dvs_cyc <= dvs_cyc + 1;
    if (hi_we) hi_cnt <= hi_cnt + 1;
    if (lo_we) lo_cnt <= lo_cnt + 1;
    if (dividend_tvalid && dividend_tready)
      cap_dvd <= dividend_tdata;
    if (divisor_tvalid && divisor_tready)
      cap_dvs <= divisor_tdata;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unsigned divider reference; x/0 -> {all ones, x}
  task automatic drive_dout();
    logic [31:0] q;
    logic [31:0] r;
    q = (cap_dvs == 0) ? 32'hFFFFFFFF : cap_dvd / cap_dvs;
    r = (cap_dvs == 0) ? cap_dvd : cap_dvd % cap_dvs;
    dout_tvalid = 1'b1;
    dout_tdata  = {q, r};
  endtask

  task automatic do_op(input string tag,
                       input logic sg,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] ma,
                       input logic [31:0] mb,
                       input int dly,
                       input int lat,
                       input int hold,
                       input logic [31:0] elo,
                       input logic [31:0] ehi);
    int d0;
    int s0;
    int h0;
    int l0;
    d0 = dvd_cyc;
    s0 = dvs_cyc;
    h0 = hi_cnt;
    l0 = lo_cnt;
    op_valid  = 1'b1;
    op_signed = sg;
    op_src1   = a;
    op_src2   = b;
    dividend_tready = 1'b1;
    divisor_tready  = (dly == 0);
    tick();
    chk({tag, ".tvalid"},
        {62'd0, dividend_tvalid, divisor_tvalid}, 64'd3);
    chk({tag, ".dvd"}, {32'd0, dividend_tdata}, {32'd0, ma});
    chk({tag, ".dvs"}, {32'd0, divisor_tdata}, {32'd0, mb});
    chk({tag, ".rdy0"}, {63'd0, op_ready}, 64'd0);
    for (int i = 0; i < dly; i++) tick();
    divisor_tready = 1'b1;
    tick();
    dividend_tready = 1'b0;
    divisor_tready  = 1'b0;
    chk({tag, ".dvd_cyc"}, 64'(dvd_cyc - d0), 64'd1);
    chk({tag, ".dvs_cyc"}, 64'(dvs_cyc - s0), 64'(dly + 1));
    chk({tag, ".wait"}, {62'd0, busy, op_ready}, 64'd2);
    for (int i = 0; i < lat; i++) tick();
    drive_dout();
    tick();
    dout_tvalid = 1'b0;
    chk({tag, ".we"}, {62'd0, hi_we, lo_we}, 64'd3);
    chk({tag, ".lo"}, {32'd0, lo_wdata}, {32'd0, elo});
    chk({tag, ".hi"}, {32'd0, hi_wdata}, {32'd0, ehi});
    chk({tag, ".rdy1"}, {63'd0, op_ready}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold"}, {62'd0, op_ready, hi_we}, 64'd2);
    end
    op_advance = 1'b1;
    op_valid   = 1'b0;
    tick();
    op_advance = 1'b0;
    chk({tag, ".idle"}, {62'd0, busy, op_ready}, 64'd0);
    chk({tag, ".pulses"}, {32'(hi_cnt - h0), 32'(lo_cnt - l0)},
        {32'd1, 32'd1});
    chk({tag, ".no_reissue"},
        {32'(dvd_cyc - d0), 32'(dvs_cyc - s0)},
        {32'd1, 32'(dly + 1)});
  endtask

  initial begin
    int h0;
    resetn          = 1'b0;
    op_valid        = 1'b0;
    op_signed       = 1'b0;
    op_src1         = '0;
    op_src2         = '0;
    op_flush        = 1'b0;
    op_advance      = 1'b0;
    dividend_tready = 1'b0;
    divisor_tready  = 1'b0;
    dout_tvalid     = 1'b0;
    dout_tdata      = '0;
    tick();
    tick();
    chk("rst.ctl",
        {58'd0, busy, op_ready, dividend_tvalid, divisor_tvalid,
         hi_we, lo_we}, 64'd0);
    chk("rst.data", {hi_wdata, lo_wdata}, 64'd0);
    resetn = 1'b1;
    tick();

    do_op("div7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd2,
          0, 2, 0, 32'hFFFFFFFD, 32'h00000001);
    do_op("divm7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'd7, 32'd2,
          3, 1, 0, 32'hFFFFFFFD, 32'hFFFFFFFF);
    do_op("div_min", 1'b1, 32'h80000000, 32'hFFFFFFFF,
          32'h80000000, 32'd1, 1, 0, 0, 32'h80000000, 32'd0);
    do_op("divu_big", 1'b0, 32'hFFFFFFFF, 32'h10, 32'hFFFFFFFF,
          32'h10, 0, 3, 3, 32'h0FFFFFFF, 32'h0000000F);

    // Flush while waiting on the divider
    h0 = hi_cnt;
    op_valid  = 1'b1;
    op_signed = 1'b0;
    op_src1   = 32'd100;
    op_src2   = 32'd7;
    dividend_tready = 1'b1;
    divisor_tready  = 1'b1;
    tick();
    tick();
    dividend_tready = 1'b0;
    divisor_tready  = 1'b0;
    op_flush = 1'b1;
    op_valid = 1'b0;
    tick();
    op_flush = 1'b0;
    chk("flush.busy", {63'd0, busy}, 64'd1);
    tick();
    drive_dout();
    tick();
    dout_tvalid = 1'b0;
    chk("flush.done",
        {61'd0, busy, op_ready, hi_we | lo_we}, 64'd0);
    tick();
    chk("flush.nowe", 64'(hi_cnt - h0), 64'd0);

    do_op("divu10_3", 1'b0, 32'd10, 32'd3, 32'd10, 32'd3,
          0, 1, 0, 32'd3, 32'd1);
    do_op("divu_zero", 1'b0, 32'd5, 32'd0, 32'd5, 32'd0,
          0, 1, 0, 32'hFFFFFFFF, 32'd5);

    // Asynchronous reset while in WAIT
    op_valid  = 1'b1;
    op_signed = 1'b0;
    op_src1   = 32'd9;
    op_src2   = 32'd2;
    dividend_tready = 1'b1;
    divisor_tready  = 1'b1;
    tick();
    tick();
    dividend_tready = 1'b0;
    divisor_tready  = 1'b0;
    chk("arst.pre", {63'd0, busy}, 64'd1);
    #2;
    resetn   = 1'b0;
    op_valid = 1'b0;
    #1;
    chk("arst.ctl",
        {58'd0, busy, op_ready, dividend_tvalid, divisor_tvalid,
         hi_we, lo_we}, 64'd0);
    chk("arst.wdata", {hi_wdata, lo_wdata}, 64'd0);
    chk("arst.tdata", {dividend_tdata, divisor_tdata}, 64'd0);
    tick();
    resetn = 1'b1;
    h0 = hi_cnt;
    dout_tvalid = 1'b1;
    dout_tdata  = {32'd4, 32'd1};
    tick();
    dout_tvalid = 1'b0;
    chk("stray.dout", {62'd0, busy, hi_we}, 64'd0);
    tick();
    chk("stray.nowe", 64'(hi_cnt - h0), 64'd0);

    do_op("post_rst", 1'b1, 32'd100, 32'hFFFFFFF9, 32'd100,
          32'd7, 2, 2, 0, 32'hFFFFFFF2, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand width (HI/LO width).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port op_valid  input  1  EX stage holds a valid DIV/DIVU.
REQ-005 SHALL have port op_signed  input  1  1 = DIV, 0 = DIVU.
REQ-006 SHALL have port op_src1  input  DATA_W  dividend (rs).
REQ-007 SHALL have port op_src2  input  DATA_W  divisor (rt).
REQ-008 SHALL have port op_flush  input  1  cancel current op (exception/refetch).
REQ-009 SHALL have port op_advance  input  1  EX stage hands the op to MEM this cycle.
REQ-010 SHALL have port op_ready  output  1  result committed, stage may advance (es_ready_go term).
REQ-011 SHALL have port busy  output  1  state is not IDLE.
REQ-012 SHALL have ports dividend_tvalid out 1, dividend_tready in 1, dividend_tdata out DATA_W  divider dividend stream.
REQ-013 SHALL have ports divisor_tvalid out 1, divisor_tready in 1, divisor_tdata out DATA_W  divider divisor stream.
REQ-014 SHALL have ports dout_tvalid in 1, dout_tdata in 2*DATA_W  divider result, {quotient, remainder}.
REQ-015 SHALL have ports hi_we out 1, hi_wdata out DATA_W, lo_we out 1, lo_wdata out DATA_W  HI/LO write port.

Function
REQ-016 SHALL implement states IDLE, SEND, WAIT, DONE.
REQ-017 IDLE: on op_valid && !op_flush SHALL latch |src1|, |src2| (magnitudes when op_signed, raw otherwise), q_neg = signed && (s1[31]^s2[31]), r_neg = signed && s1[31]; go SEND.
REQ-018 SEND: dividend_tvalid and divisor_tvalid SHALL assert from the first SEND cycle; each SHALL drop the cycle after its own tvalid&&tready, independently; tdata SHALL stay stable while tvalid is high.
REQ-019 SEND -> WAIT SHALL occur once both channels have handshaken (same cycle allowed); minimum SEND duration 1 cycle.
REQ-020 WAIT: on dout_tvalid SHALL pulse hi_we and lo_we for exactly 1 cycle with lo_wdata = q_neg ? -Q : Q, hi_wdata = r_neg ? -R : R (mod 2^DATA_W); go DONE.
REQ-021 DONE: op_ready SHALL be 1; on op_advance SHALL go IDLE; no new op SHALL be issued while in DONE, even with op_valid held.
REQ-022 op_ready SHALL be 0 in IDLE, SEND, WAIT.
REQ-023 op_flush in SEND/WAIT SHALL set a drop flag; the pending stream handshakes and dout SHALL still complete (AXI-stream tvalid is never withdrawn); on dout_tvalid no hi_we/lo_we SHALL pulse and state SHALL go IDLE.
REQ-024 op_flush in DONE SHALL go IDLE (HI/LO already written stays written).
REQ-025 Divide by zero SHALL be passed to the divider unchanged; HI/LO get whatever it returns, no stall or exception.
REQ-026 0x80000000 signed SHALL yield magnitude 0x80000000 (unsigned interpretation of negate).
REQ-027 Latency op accept -> op_ready SHALL be SEND cycles + divider latency + 1.

Reset
REQ-028 resetn low SHALL force state IDLE, drop flag 0, and all outputs 0 (tvalids, hi_we, lo_we, op_ready, busy, all data) asynchronously, including mid-SEND/WAIT.
REQ-029 After resetn release the first op SHALL be accepted normally; a stray dout_tvalid in IDLE SHALL be ignored.

Structure
REQ-030 State encoding, DATA_W default and result-bus field offsets SHALL live in the shared mycpu package/header.
REQ-031 Sign handling SHALL be one combinational sub-module div_sign_fix (magnitude in, sign-corrected Q/R out), used for both pre- and post-correction.

Verification
REQ-032 DIV 7 / -2 -> lo_wdata 0xFFFFFFFD, hi_wdata 0x00000001, single hi_we/lo_we pulse.
REQ-033 DIV -7 / 2 -> lo_wdata 0xFFFFFFFD, hi_wdata 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo 0x80000000, hi 0.
REQ-034 DIVU 0xFFFFFFFF / 0x10 -> lo 0x0FFFFFFF, hi 0x0000000F.
REQ-035 dividend_tready immediate, divisor_tready after 3 cycles -> dividend_tvalid high 1 cycle, divisor_tvalid high 4 cycles, exactly one result accepted.
REQ-036 op_flush in WAIT -> no hi_we/lo_we, IDLE after dout_tvalid; next DIVU 10/3 -> lo 3, hi 1.
REQ-037 op_advance low 4 cycles in DONE with op_valid held -> op_ready high 4 cycles, no new tvalid; resetn pulse in WAIT -> all outputs 0 immediately.
